// File: rtl/traffic_time_display_if.sv
// rtl/traffic_time_display_if.sv - countdown inputs and segment/digit outputs of the display driver
interface traffic_time_display_if;
    logic [5:0] A_time;
    logic [5:0] B_time;
    logic [7:0] seg;
    logic [3:0] dig_sel;

    modport master (
        output A_time,
        output B_time,
        input  seg,
        input  dig_sel
    );

    modport slave (
        input  A_time,
        input  B_time,
        output seg,
        output dig_sel
    );
endinterface

// File: rtl/traffic_time_display.sv
// rtl/traffic_time_display.sv - 4-digit multiplexed seven-segment driver for two road countdowns
module traffic_time_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_TH     = 3,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    traffic_time_display_if.slave  disp
);
    localparam int              DW         = $clog2(SCAN_DIV);
    localparam int              FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0]   DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]   DIV_LOAD   = DW'(1);
    localparam logic [FW-1:0]   FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [5:0]      BLINK_MAX  = 6'(BLINK_TH);

    logic [DW-1:0] div_cnt;
    logic [1:0]    slot;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [5:0]    a_s;
    logic [5:0]    b_s;

    logic [5:0]    road_val;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    slot_pat;
    logic [3:0]    slot_sel;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b0000000;
        endcase
    endfunction

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [5:0] t;
        t = v / 6'd10;
        return t[3:0];
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        logic [5:0] t;
        t = v % 6'd10;
        return t[3:0];
    endfunction

    // Odd slots carry tens digits, upper slots belong to road A.
    always_comb begin
        road_val = slot[1] ? a_s : b_s;
        digit    = slot[0] ? tens_of(road_val) : ones_of(road_val);
        blank    = (slot[0] && (digit == 4'd0)) ||
                   (blink_phase && (road_val != 6'd0) && (road_val <= BLINK_MAX));
        slot_pat = blank ? 7'd0 : decode(digit);
        case (slot)
            2'd0:    slot_sel = 4'b1110;
            2'd1:    slot_sel = 4'b1101;
            2'd2:    slot_sel = 4'b1011;
            default: slot_sel = 4'b0111;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            div_cnt      <= '0;
            slot         <= 2'd0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b0;
            a_s          <= 6'd0;
            b_s          <= 6'd0;
            disp.seg     <= 8'h00;
            disp.dig_sel <= 4'b1111;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt      <= '0;
                slot         <= slot + 2'd1;
                // Guard cycle: all digits off before the next slot's pattern lands.
                disp.dig_sel <= 4'b1111;
                if (slot == 2'd3) begin
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + FW'(1);
                    end
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end

            if ((div_cnt == '0) && (slot == 2'd0)) begin
                a_s <= disp.A_time;
                b_s <= disp.B_time;
            end

            if (div_cnt == DIV_LOAD) begin
                disp.seg     <= {1'b0, slot_pat};
                disp.dig_sel <= slot_sel;
            end
        end
    end
endmodule
